// File: rtl/memory_cycle.sv
// Memory stage of the RV32I pipeline: byte/half/word loads and stores against a
// word-addressed data RAM with optional wait states, registered into the W stage.
//
// state | meaning
// IDLE  | no access in flight; non-access and misaligned ops complete in one cycle
// BUSY  | aligned access counting wait states; completes when cnt reaches 0
module memory_cycle #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   output logic        StallM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic        MisalignW
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic        reg_write_q, reg_write_d;
   logic [1:0]  result_src_q, result_src_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        misalign_q, misalign_d;

   logic        is_store, is_load, is_access, is_byte, is_half;
   logic        misaligned, aligned_acc, stall, complete, store_commit;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rword, wdata, load_ext;
   logic [3:0]  be;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Store wins when both request bits are set.
   assign is_store    = MemWriteM;
   assign is_load     = (ResultSrcM == 2'b01) && !MemWriteM;
   assign is_access   = MemWriteM || (ResultSrcM == 2'b01);
   assign is_byte     = (Funct3M[1:0] == 2'b00);
   assign is_half     = (Funct3M[1:0] == 2'b01);
   assign misaligned  = (is_half && ALU_ResultM[0]) ||
                        (!is_byte && !is_half && (ALU_ResultM[1:0] != 2'b00));
   assign aligned_acc = is_access && !misaligned;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      complete = 1'b0;
      if (WAIT_STATES == 0) begin
         complete = aligned_acc;
      end else if (state_q == IDLE) begin
         if (aligned_acc) begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
         end
      end else begin
         if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_d = cnt_q - CW'(1);
         end else begin
            complete = 1'b1;
            state_d  = IDLE;
         end
      end
   end

   // Held low through reset even if upstream still presents an access.
   assign StallM = stall && rst;

   assign idx   = ALU_ResultM[AW+1:2];
   assign rword = mem[idx];

   always_comb begin
      case (Funct3M[1:0])
         2'b00: begin
            be    = 4'b0001 << ALU_ResultM[1:0];
            wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be    = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = WriteDataM;
         end
      endcase
   end

   assign store_commit = complete && is_store && rst;

   always_ff @(posedge clk) begin
      if (store_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      case (ALU_ResultM[1:0])
         2'b00:   lane_b = rword[7:0];
         2'b01:   lane_b = rword[15:8];
         2'b10:   lane_b = rword[23:16];
         default: lane_b = rword[31:24];
      endcase
      lane_h = ALU_ResultM[1] ? rword[31:16] : rword[15:0];
      case (Funct3M)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_ext = {24'h0, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_ext = {16'h0, lane_h};
         default: load_ext = rword;
      endcase
   end

   // A stall cycle shifts a bubble into W; data fields keep their last value.
   always_comb begin
      reg_write_d  = reg_write_q;
      result_src_d = result_src_q;
      rd_d         = rd_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      pc_plus4_d   = pc_plus4_q;
      misalign_d   = misalign_q;
      if (stall) begin
         reg_write_d  = 1'b0;
         result_src_d = 2'b00;
         rd_d         = 5'd0;
         misalign_d   = 1'b0;
      end else begin
         reg_write_d  = RegWriteM;
         result_src_d = ResultSrcM;
         rd_d         = RD_M;
         alu_result_d = ALU_ResultM;
         pc_plus4_d   = PCPlus4M;
         misalign_d   = is_access && misaligned;
         read_data_d  = (complete && is_load) ? load_ext : 32'h0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         reg_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         rd_q         <= 5'd0;
         alu_result_q <= 32'h0;
         read_data_q  <= 32'h0;
         pc_plus4_q   <= 32'h0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         pc_plus4_q   <= pc_plus4_d;
         misalign_q   <= misalign_d;
      end
   end

   assign RegWriteW   = reg_write_q;
   assign ResultSrcW  = result_src_q;
   assign RD_W        = rd_q;
   assign ALU_ResultW = alu_result_q;
   assign ReadDataW   = read_data_q;
   assign PCPlus4W    = pc_plus4_q;
   assign MisalignW   = misalign_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: two instances (1 and 3 wait states) driven by directed
// ops, checked every cycle against a byte-array memory model.
module tb_memory_cycle;

   localparam int D1 = 1024;
   localparam int D3 = 64;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [31:0] pc;
   } req_t;

   typedef struct {
      logic        reg_write;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc;
      logic        mis;
      logic        rdv;
   } w_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   req_t req1 = '0;
   req_t req3 = '0;

   logic        stall1, rw1, mis1, stall3, rw3, mis3;
   logic [1:0]  rs1, rs3;
   logic [4:0]  rdw1, rdw3;
   logic [31:0] aluw1, rdata1, pcw1, aluw3, rdata3, pcw3;

   memory_cycle #(.DEPTH_WORDS(D1), .WAIT_STATES(1)) u1 (
      .clk(clk), .rst(rst),
      .RegWriteM(req1.reg_write), .MemWriteM(req1.mem_write), .ResultSrcM(req1.rs),
      .Funct3M(req1.f3), .ALU_ResultM(req1.addr), .WriteDataM(req1.wd),
      .RD_M(req1.rd), .PCPlus4M(req1.pc),
      .StallM(stall1), .RegWriteW(rw1), .ResultSrcW(rs1), .RD_W(rdw1),
      .ALU_ResultW(aluw1), .ReadDataW(rdata1), .PCPlus4W(pcw1), .MisalignW(mis1)
   );

   memory_cycle #(.DEPTH_WORDS(D3), .WAIT_STATES(3)) u3 (
      .clk(clk), .rst(rst),
      .RegWriteM(req3.reg_write), .MemWriteM(req3.mem_write), .ResultSrcM(req3.rs),
      .Funct3M(req3.f3), .ALU_ResultM(req3.addr), .WriteDataM(req3.wd),
      .RD_M(req3.rd), .PCPlus4M(req3.pc),
      .StallM(stall3), .RegWriteW(rw3), .ResultSrcW(rs3), .RD_W(rdw3),
      .ALU_ResultW(aluw3), .ReadDataW(rdata3), .PCPlus4W(pcw3), .MisalignW(mis3)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   which = 1;
   logic chk_en = 1'b0;
   logic exp_stall = 1'b0;
   w_t   exp_w, w_pend;
   logic [7:0] mb1 [int];
   logic [7:0] mb3 [int];
   logic [31:0] rdm;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input logic s, input w_t a);
      chk("StallM", 32'(s), 32'(exp_stall));
      chk("RegWriteW", 32'(a.reg_write), 32'(exp_w.reg_write));
      chk("ResultSrcW", 32'(a.rs), 32'(exp_w.rs));
      chk("RD_W", 32'(a.rd), 32'(exp_w.rd));
      chk("ALU_ResultW", a.alu, exp_w.alu);
      chk("PCPlus4W", a.pc, exp_w.pc);
      chk("MisalignW", 32'(a.mis), 32'(exp_w.mis));
      if (exp_w.rdv) chk("ReadDataW", a.rdata, exp_w.rdata);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (which == 1) cmp_all(stall1, w_t'{rw1, rs1, rdw1, aluw1, rdata1, pcw1, mis1, 1'b1});
         else            cmp_all(stall3, w_t'{rw3, rs3, rdw3, aluw3, rdata3, pcw3, mis3, 1'b1});
      end
   end

   // Byte-addressed model memory; addresses wrap at the RAM size in bytes.
   function automatic int bidx(input int w, input logic [31:0] a);
      logic [31:0] m;
      m = (w == 1) ? 32'(D1 * 4) : 32'(D3 * 4);
      return int'(a % m);
   endfunction

   function automatic logic [7:0] rdb(input int w, input logic [31:0] a);
      int k;
      k = bidx(w, a);
      if (w == 1) return mb1.exists(k) ? mb1[k] : 8'h00;
      return mb3.exists(k) ? mb3[k] : 8'h00;
   endfunction

   task automatic wrb(input int w, input logic [31:0] a, input logic [7:0] v);
      if (w == 1) mb1[bidx(w, a)] = v;
      else        mb3[bidx(w, a)] = v;
   endtask

   task automatic drive(input int w, input req_t r);
      if (w == 1) req1 = r;
      else        req3 = r;
   endtask

   function automatic req_t mk(input logic rw, input logic mw, input logic [1:0] rs,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] pc);
      return '{rw, mw, rs, f3, a, wd, rd, pc};
   endfunction

   function automatic req_t st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      return mk(1'b0, 1'b1, 2'b00, f3, a, wd, 5'd0, a + 32'h1000);
   endfunction

   function automatic req_t ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
      return mk(1'b1, 1'b0, 2'b01, f3, a, 32'h0, rd, a + 32'h2000);
   endfunction

   task automatic bubble_pend();
      w_pend.reg_write = 1'b0;
      w_pend.rs        = 2'b00;
      w_pend.rd        = 5'd0;
      w_pend.mis       = 1'b0;
   endtask

   // One instruction followed by one idle cycle; enter and leave at posedge+1.
   task automatic run_op(input int w, input req_t r, output logic [31:0] model_rdata);
      int ws, sz, n;
      logic sgn, is_st, is_ld, acc, mis;
      logic [31:0] v;
      w_t res;
      ws    = (w == 1) ? 1 : 3;
      is_st = r.mem_write;
      is_ld = !r.mem_write && (r.rs == 2'b01);
      acc   = is_st || is_ld;
      case (r.f3)
         3'b000:  begin sz = 1; sgn = 1'b1; end
         3'b100:  begin sz = 1; sgn = 1'b0; end
         3'b001:  begin sz = 2; sgn = 1'b1; end
         3'b101:  begin sz = 2; sgn = 1'b0; end
         default: begin sz = 4; sgn = 1'b0; end
      endcase
      mis = acc && ((r.addr % 32'(sz)) != 0);
      v = 32'h0;
      if (is_ld && !mis) begin
         for (int i = 0; i < sz; i++) v[8*i +: 8] = rdb(w, r.addr + 32'(i));
         if (sgn && sz == 1) v = {{24{v[7]}}, v[7:0]};
         if (sgn && sz == 2) v = {{16{v[15]}}, v[15:0]};
      end
      model_rdata = v;
      res = '{r.reg_write, r.rs, r.rd, r.addr, v, r.pc, mis, is_ld || mis};
      n = (acc && !mis) ? ws : 0;
      for (int c = 0; c <= n; c++) begin
         drive(w, r);
         exp_stall = (c < n);
         exp_w     = w_pend;
         @(posedge clk);
         if (c < n) bubble_pend();
         else begin
            w_pend = res;
            if (is_st && !mis)
               for (int i = 0; i < sz; i++) wrb(w, r.addr + 32'(i), r.wd[8*i +: 8]);
         end
         #1;
      end
      drive(w, '0);
      exp_stall = 1'b0;
      exp_w     = w_pend;
      @(posedge clk);
      w_pend = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      w_pend    = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
      exp_w     = w_pend;
      exp_stall = 1'b0;
      chk_en    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst3_StallM", 32'(stall3), 32'h0);
      chk("rst3_ReadDataW", rdata3, 32'h0);
      chk("rst3_PCPlus4W", pcw3, 32'h0);
      #1 rst = 1'b1;
      w_pend.rdv = 1'b0;
      @(posedge clk);
      exp_w = w_pend;
      #1;

      // 1 wait state: basic store/load
      run_op(1, st(3'b010, 32'h10, 32'hDEADBEEF), rdm);
      run_op(1, ld(3'b010, 32'h10, 5'd5), rdm);
      chk("lw10_model", rdm, 32'hDEADBEEF);

      // sign/zero extension
      run_op(1, st(3'b010, 32'h20, 32'h80FF7F01), rdm);
      run_op(1, ld(3'b000, 32'h22, 5'd1), rdm);
      chk("lb22_model", rdm, 32'hFFFFFFFF);
      run_op(1, ld(3'b100, 32'h22, 5'd2), rdm);
      chk("lbu22_model", rdm, 32'h000000FF);
      run_op(1, ld(3'b001, 32'h22, 5'd3), rdm);
      chk("lh22_model", rdm, 32'hFFFF80FF);
      run_op(1, ld(3'b101, 32'h22, 5'd4), rdm);
      chk("lhu22_model", rdm, 32'h000080FF);
      run_op(1, ld(3'b000, 32'h20, 5'd6), rdm);
      chk("lb20_model", rdm, 32'h00000001);

      // partial stores
      run_op(1, st(3'b010, 32'h30, 32'h11223344), rdm);
      run_op(1, st(3'b000, 32'h33, 32'hFFFFFFAB), rdm);
      run_op(1, ld(3'b010, 32'h30, 5'd7), rdm);
      chk("sb33_model", rdm, 32'hAB223344);
      run_op(1, st(3'b001, 32'h30, 32'h12345566), rdm);
      run_op(1, ld(3'b010, 32'h30, 5'd8), rdm);
      chk("sh30_model", rdm, 32'hAB225566);
      run_op(1, ld(3'b101, 32'h32, 5'd9), rdm);
      chk("lhu32_model", rdm, 32'h0000AB22);

      // misaligned, then prove RAM untouched; reserved funct3 reads a word
      run_op(1, ld(3'b010, 32'h06, 5'd10), rdm);
      run_op(1, st(3'b001, 32'h31, 32'h0000FFFF), rdm);
      run_op(1, ld(3'b011, 32'h30, 5'd11), rdm);
      chk("misal_unchanged_model", rdm, 32'hAB225566);

      // non-access passthrough and address wrap
      run_op(1, mk(1'b1, 1'b0, 2'b00, 3'b000, 32'h00001234, 32'h0, 5'd12, 32'h44), rdm);
      run_op(1, st(3'b010, 32'(D1 * 4 + 8), 32'h0BADF00D), rdm);
      run_op(1, ld(3'b010, 32'h8, 5'd13), rdm);
      chk("wrap_model", rdm, 32'h0BADF00D);

      // 3 wait states
      which = 3;
      w_pend = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      run_op(3, mk(1'b1, 1'b0, 2'b00, 3'b000, 32'h00000777, 32'h0, 5'd3, 32'h88), rdm);
      run_op(3, st(3'b010, 32'h40, 32'hCAFEF00D), rdm);
      run_op(3, ld(3'b010, 32'h40, 5'd6), rdm);
      chk("ws3_lw_model", rdm, 32'hCAFEF00D);

      // reset during the second stall cycle of a store
      drive(3, st(3'b010, 32'h40, 32'h12345678));
      exp_stall = 1'b1;
      exp_w     = w_pend;
      @(posedge clk);
      bubble_pend();
      #1;
      exp_w = w_pend;
      @(negedge clk);
      #2;
      chk_en = 1'b0;
      rst    = 1'b0;
      #1;
      chk("rstmid_StallM", 32'(stall3), 32'h0);
      chk("rstmid_RegWriteW", 32'(rw3), 32'h0);
      chk("rstmid_RD_W", 32'(rdw3), 32'h0);
      chk("rstmid_ResultSrcW", 32'(rs3), 32'h0);
      chk("rstmid_ALU_ResultW", aluw3, 32'h0);
      chk("rstmid_ReadDataW", rdata3, 32'h0);
      chk("rstmid_PCPlus4W", pcw3, 32'h0);
      chk("rstmid_MisalignW", 32'(mis3), 32'h0);
      drive(3, '0);
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      w_pend = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      chk_en = 1'b1;
      run_op(3, ld(3'b010, 32'h40, 5'd14), rdm);
      chk("discarded_store_model", rdm, 32'hCAFEF00D);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory-stage responder of the RV32I pipeline.
- Consumes the M-stage request bundle from the execute stage: address, store data, write enable, load select and access size.
- Performs byte/halfword/word loads and stores against an internal word-addressed data RAM, with a configurable number of wait states.
- Asserts a stall to the hazard unit while an access is in flight, then registers the result into the W stage.

Parameters:
- DEPTH_WORDS, 1024: data RAM depth in 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- WAIT_STATES, 1: extra cycles per load/store; 0 gives single-cycle access with no stall.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RegWriteM  in  1  register write enable, forwarded to W
- MemWriteM  in  1  store request
- ResultSrcM  in  2  result select; 2'b01 = load request
- Funct3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALU_ResultM  in  32  byte address, or ALU result for non-memory operations
- WriteDataM  in  32  store data; low bytes are used for sb/sh
- RD_M  in  5  destination register
- PCPlus4M  in  32  link value
- StallM  out  1  access in flight; upstream holds all M inputs stable and freezes F/D/E
- RegWriteW  out  1  registered write enable
- ResultSrcW  out  2  registered result select
- RD_W  out  5  registered destination register
- ALU_ResultW  out  32  registered ALU result
- ReadDataW  out  32  registered, extended load data
- PCPlus4W  out  32  registered link value
- MisalignW  out  1  registered misaligned-access flag for the completing instruction

Behaviour:
- Access definition: access = MemWriteM | (ResultSrcM==2'b01).
  - Both set at once is illegal; the store has priority.
  - Non-access operations pass M to W in one cycle with no stall.
- Alignment check:
  - misaligned = (h/hu and addr[0]) | (w and addr[1:0]!=0).
  - A misaligned access never stalls and never writes RAM.
  - It completes in one cycle with ReadDataW=0 and MisalignW=1.
  - RegWriteW still follows RegWriteM; trap handling belongs to a later block.
- FSM states: IDLE, BUSY; wait counter cnt is ceil(log2(WAIT_STATES+1)) bits.
  - IDLE, aligned access, WAIT_STATES>0: StallM=1 combinationally; next state BUSY, cnt<=WAIT_STATES-1.
  - BUSY, cnt!=0: StallM=1, cnt decrements.
  - BUSY, cnt==0: StallM=0, the access completes at this edge (store commits, W regs capture), next state IDLE.
  - WAIT_STATES==0: the FSM stays in IDLE; every aligned access completes at the edge of its first cycle.
- While StallM=1, W regs load a bubble: RegWriteW=0, RD_W=0, MisalignW=0, ResultSrcW=00. Data fields hold their previous values.
- Store byte lanes, index = addr[AW+1:2]:
  - sb writes lane addr[1:0] with WriteDataM[7:0].
  - sh writes lanes {addr[1],1} and {addr[1],0} with WriteDataM[15:0].
  - sw writes all four lanes.
  - Other lanes are untouched.
- Address wrap: address bits above AW+1 are ignored, so the index wraps modulo DEPTH_WORDS.
- Load: the RAM word is read at the completing cycle, then lane-selected and extended.
  - lb/lh sign-extend from bit 7/15.
  - lbu/hu zero-extend.
  - lw passes the word through.
  - A load issued one cycle after a store to the same word sees the new data.
- Reserved Funct3M values (011, 110, 111) on an access: treated as word.
- Reset (asynchronous, any time, including mid-BUSY):
  - state=IDLE, cnt=0, all W outputs 0, StallM=0.
  - An in-flight store is discarded.
  - RAM contents are not reset.

Test Plan:
- WAIT_STATES=1: sw 0xDEADBEEF to 0x10, then lw 0x10 with RD=5 → StallM high exactly 1 cycle per access; ReadDataW=0xDEADBEEF, RD_W=5, RegWriteW=1 one cycle after stall drops.
- Memory preloaded with 0x80FF7F01 at 0x20: lb/lbu at 0x22 → 0xFFFFFFFF/0x000000FF; lh/lhu at 0x22 → 0xFFFF80FF/0x000080FF; lb 0x20 → 0x00000001.
- sb 0xAB to 0x33 over word 0x11223344 → word reads 0xAB223344; sh 0x5566 to 0x30 → 0xAB225566.
- lw 0x06 and sh 0x31 → MisalignW=1, ReadDataW=0, no stall, RAM unchanged.
- WAIT_STATES=3: add (no access) → 1-cycle passthrough; a following lw → StallM high 3 cycles with bubbles on W; rst pulled low during the 2nd stall cycle of a sw → store not committed, all outputs 0.
- Address wrap: sw to DEPTH_WORDS*4+8 then lw 0x8 → same data.
